// File: rtl/hub75_scanner_if.sv
// hub75_scanner_if
//   Groups the scanner's two buses: the pixel query/answer bus towards the
//   painter, and the HUB75 panel drive lines.
//   master : the scanner (drives queries and panel lines, receives rgb)
//   slave  : the painter/panel side (answers rgb, observes everything else)
//   Signals:
//     frame[12:0]    frame counter to painter
//     x[5:0], y[5:0] pixel query to painter
//     rgb[2:0]       painter answer {B,G,R}
//     led_rgb0/1     top/bottom-half panel data {B,G,R}
//     led_addr[4:0]  row-pair address
//     led_clk        panel shift clock
//     led_lat        panel latch strobe
//     led_oe_n       panel output enable, active low
interface hub75_scanner_if;
    logic [12:0] frame;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [2:0]  rgb;
    logic [2:0]  led_rgb0;
    logic [2:0]  led_rgb1;
    logic [4:0]  led_addr;
    logic        led_clk;
    logic        led_lat;
    logic        led_oe_n;

    modport master (
        output frame, x, y,
        output led_rgb0, led_rgb1, led_addr, led_clk, led_lat, led_oe_n,
        input  rgb
    );

    modport slave (
        input  frame, x, y,
        input  led_rgb0, led_rgb1, led_addr, led_clk, led_lat, led_oe_n,
        output rgb
    );
endinterface

// File: rtl/hub75_scanner.sv
// hub75_scanner
//   Row-scan engine for a 64x64, 1/32-scan HUB75 panel. Issues one pixel
//   query per clock to the painter (alternating top row / bottom row of the
//   current row pair), pairs the answers, shifts 64 columns into the panel,
//   then blanks, latches and displays the row pair for ON_CYCLES clocks.
//   Parameters:
//     PAINT_LAT  clocks from x/y to valid rgb (1..4)
//     ON_CYCLES  clocks led_oe_n is held low per row (1..4095)
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    hub75_scanner_if.master (painter query bus + panel lines)
//   All outputs come straight from flops.
module hub75_scanner #(
    parameter int PAINT_LAT = 1,
    parameter int ON_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    hub75_scanner_if.master        bus
);

    typedef enum logic [2:0] {
        SHIFT,
        DRAIN,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    localparam logic [11:0] DRAIN_LAST = 12'(PAINT_LAT + 1);
    localparam logic [11:0] ON_LAST    = 12'(ON_CYCLES - 1);

    state_t      state_q, state_d;
    logic [6:0]  q_q, q_d;
    logic [11:0] cnt_q, cnt_d;
    logic [4:0]  row_q, row_d;
    logic [12:0] frame_q, frame_d;
    logic [5:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [2:0]  top_q, top_d;
    logic [2:0]  rgb0_q, rgb0_d;
    logic [2:0]  rgb1_q, rgb1_d;
    logic [4:0]  addr_q, addr_d;
    logic        led_clk_q, led_clk_d;
    logic        lat_q, lat_d;
    logic        oe_n_q, oe_n_d;
    logic        pulse_q, pulse_d;

    // Tag travelling alongside each query: valid (query issued in SHIFT)
    // and half (0 = top row, 1 = bottom row). Stage PAINT_LAT-1 lines up
    // with the painter's answer for that query.
    logic [PAINT_LAT-1:0] tag_v_q, tag_v_d;
    logic [PAINT_LAT-1:0] tag_h_q, tag_h_d;

    logic [6:0] q_next;
    assign q_next = q_q + 7'd1;

    assign tag_v_d[0] = (state_q == SHIFT);
    assign tag_h_d[0] = q_q[0];

    generate
        for (genvar gi = 1; gi < PAINT_LAT; gi++) begin : g_tag
            assign tag_v_d[gi] = tag_v_q[gi-1];
            assign tag_h_d[gi] = tag_h_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        frame_d   = frame_q;
        x_d       = x_q;
        y_d       = y_q;
        top_d     = top_q;
        rgb0_d    = rgb0_q;
        rgb1_d    = rgb1_q;
        addr_d    = addr_q;
        pulse_d   = 1'b0;
        // The shift clock rises one clock after new data is presented, so
        // data is always stable across the rising edge, and falls again on
        // the next clock (2-clock period).
        led_clk_d = pulse_q;
        lat_d     = 1'b0;
        oe_n_d    = 1'b1;

        // Answer capture: top half is parked, bottom half completes the
        // pair and both go to the panel data lines together.
        if (tag_v_q[PAINT_LAT-1]) begin
            if (!tag_h_q[PAINT_LAT-1]) begin
                top_d = bus.rgb;
            end else begin
                rgb0_d  = top_q;
                rgb1_d  = bus.rgb;
                pulse_d = 1'b1;
            end
        end

        case (state_q)
            SHIFT: begin
                q_d = q_next;
                if (q_q == 7'd127) begin
                    state_d = DRAIN;
                    cnt_d   = 12'd0;
                end else begin
                    x_d = q_next[6:1];
                    y_d = {q_next[0], row_q};   // +32 selects the bottom half
                end
            end
            DRAIN: begin
                // Lets the last answers arrive and the column-63 pulse finish.
                if (cnt_q == DRAIN_LAST) begin
                    state_d = BLANK;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            BLANK: begin
                state_d = LATCH;
                lat_d   = 1'b1;
                addr_d  = row_q;
            end
            LATCH: begin
                state_d = DISPLAY;
                cnt_d   = 12'd0;
                oe_n_d  = 1'b0;
            end
            DISPLAY: begin
                if (cnt_q == ON_LAST) begin
                    state_d = SHIFT;
                    q_d     = 7'd0;
                    row_d   = row_q + 5'd1;
                    if (row_q == 5'd31) begin
                        frame_d = frame_q + 13'd1;
                    end
                    x_d = 6'd0;
                    y_d = {1'b0, row_q + 5'd1};
                end else begin
                    cnt_d  = cnt_q + 12'd1;
                    oe_n_d = 1'b0;
                end
            end
            default: begin
                state_d = SHIFT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SHIFT;
            q_q       <= 7'd0;
            cnt_q     <= 12'd0;
            row_q     <= 5'd0;
            frame_q   <= 13'd0;
            x_q       <= 6'd0;
            y_q       <= 6'd0;
            top_q     <= 3'd0;
            rgb0_q    <= 3'd0;
            rgb1_q    <= 3'd0;
            addr_q    <= 5'd0;
            led_clk_q <= 1'b0;
            lat_q     <= 1'b0;
            oe_n_q    <= 1'b1;
            pulse_q   <= 1'b0;
            tag_v_q   <= '0;
            tag_h_q   <= '0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            x_q       <= x_d;
            y_q       <= y_d;
            top_q     <= top_d;
            rgb0_q    <= rgb0_d;
            rgb1_q    <= rgb1_d;
            addr_q    <= addr_d;
            led_clk_q <= led_clk_d;
            lat_q     <= lat_d;
            oe_n_q    <= oe_n_d;
            pulse_q   <= pulse_d;
            tag_v_q   <= tag_v_d;
            tag_h_q   <= tag_h_d;
        end
    end

    assign bus.frame    = frame_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.led_rgb0 = rgb0_q;
    assign bus.led_rgb1 = rgb1_q;
    assign bus.led_addr = addr_q;
    assign bus.led_clk  = led_clk_q;
    assign bus.led_lat  = lat_q;
    assign bus.led_oe_n = oe_n_q;

endmodule
